// File: rtl/bus_sequencer.sv
// Micro-op sequencer feeding the CPU data bus: walks each decoded op through
// address, wait, route and write phases, driving per-destination selectors and write enables.
module bus_sequencer #(
    parameter int SELECTOR_WIDTH = 4,
    parameter int NUM_DEST       = 11,
    parameter int MEM_TIMEOUT    = 15
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [2:0]                op_type,
    input  logic [SELECTOR_WIDTH-1:0] src_code,
    input  logic [SELECTOR_WIDTH-1:0] dst_code,
    input  logic                      mem_ready,
    input  logic                      alu_done,
    output logic [SELECTOR_WIDTH-1:0] pc_selector,
    output logic [SELECTOR_WIDTH-1:0] sp_selector,
    output logic [SELECTOR_WIDTH-1:0] add_selector,
    output logic [SELECTOR_WIDTH-1:0] x_selector,
    output logic [SELECTOR_WIDTH-1:0] y_selector,
    output logic [SELECTOR_WIDTH-1:0] stat_selector,
    output logic [SELECTOR_WIDTH-1:0] mem_selector,
    output logic [SELECTOR_WIDTH-1:0] fetch_selector,
    output logic [SELECTOR_WIDTH-1:0] decode_selector,
    output logic [SELECTOR_WIDTH-1:0] alu0_selector,
    output logic [SELECTOR_WIDTH-1:0] alu1_selector,
    output logic [NUM_DEST-1:0]       dst_we,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);
    localparam int SW    = SELECTOR_WIDTH;
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_TRANSFER = 3'd1;
    localparam logic [2:0] OP_LOAD_IMM = 3'd2;
    localparam logic [2:0] OP_LOAD_MEM = 3'd3;
    localparam logic [2:0] OP_STORE    = 3'd4;
    localparam logic [2:0] OP_ALU      = 3'd5;

    localparam logic [SW-1:0] SRC_MEM  = SW'(7);
    localparam logic [SW-1:0] SRC_IMM  = SW'(8);
    localparam logic [SW-1:0] SRC_ALU  = SW'(11);
    localparam logic [SW-1:0] DST_ADD  = SW'(2);
    localparam logic [SW-1:0] DST_MEM  = SW'(6);
    localparam logic [SW-1:0] DST_LIM  = SW'(NUM_DEST);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ADDR, MEMWAIT, ROUTE, EXEC, WRITE, FINISH} state_t;

    state_t            state_reg, state_next;
    logic [2:0]        op_reg, op_next;
    logic [SW-1:0]     src_reg, src_next, dst_reg, dst_next;
    logic              addr_phase_reg, addr_phase_next;
    logic              result_phase_reg, result_phase_next;
    logic              err_reg, err_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;

    logic [SW-1:0]       sel_reg [NUM_DEST];
    logic [SW-1:0]       sel_next [NUM_DEST];
    logic [NUM_DEST-1:0] we_reg, we_next;
    logic                busy_reg, busy_next, done_reg, done_next, error_reg, error_next;

    // Source and destination numbering differ; these pairs name the same register.
    function automatic logic same_resource(input logic [SW-1:0] src, input logic [SW-1:0] dst);
        return ((dst <= SW'(6)) && (src == dst + SW'(1))) ||
               ((dst == SW'(7) || dst == SW'(8)) && (src == dst + SW'(2)));
    endfunction

    function automatic logic is_illegal(input logic [2:0] op, input logic [SW-1:0] src,
                                        input logic [SW-1:0] dst);
        logic bad_src, bad_dst;
        bad_src = src > SRC_ALU;
        bad_dst = dst >= DST_LIM;
        case (op)
            OP_NOP:                   return 1'b0;
            OP_TRANSFER:              return bad_dst || bad_src || same_resource(src, dst);
            OP_LOAD_IMM, OP_LOAD_MEM: return bad_dst;
            OP_STORE:                 return bad_src;
            OP_ALU:                   return bad_dst || bad_src;
            default:                  return 1'b1;
        endcase
    endfunction

    always_comb begin
        state_next        = state_reg;
        op_next           = op_reg;
        src_next          = src_reg;
        dst_next          = dst_reg;
        addr_phase_next   = addr_phase_reg;
        result_phase_next = result_phase_reg;
        err_next          = err_reg;
        cnt_next          = cnt_reg;
        case (state_reg)
            IDLE: if (start) begin
                op_next           = op_type;
                src_next          = src_code;
                dst_next          = dst_code;
                addr_phase_next   = 1'b0;
                result_phase_next = 1'b0;
                err_next          = 1'b0;
                if (is_illegal(op_type, src_code, dst_code)) begin
                    err_next   = 1'b1;
                    state_next = FINISH;
                end else begin
                    case (op_type)
                        OP_NOP:                state_next = FINISH;
                        OP_LOAD_MEM, OP_STORE: state_next = ADDR;
                        default:               state_next = ROUTE;
                    endcase
                end
            end
            ADDR: begin
                if (!addr_phase_reg) begin
                    addr_phase_next = 1'b1;
                end else begin
                    cnt_next   = '0;
                    state_next = (op_reg == OP_STORE) ? ROUTE : MEMWAIT;
                end
            end
            MEMWAIT, EXEC: begin
                if ((state_reg == MEMWAIT) ? mem_ready : alu_done) begin
                    if (state_reg == EXEC) begin
                        result_phase_next = 1'b1;
                        state_next        = ROUTE;
                    end else begin
                        state_next = (op_reg == OP_STORE) ? FINISH : ROUTE;
                    end
                end else if (cnt_reg == WAIT_LAST) begin
                    err_next   = 1'b1;
                    state_next = FINISH;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ROUTE: state_next = WRITE;
            WRITE: begin
                cnt_next = '0;
                if (op_reg == OP_STORE)
                    state_next = MEMWAIT;
                else if (op_reg == OP_ALU && !result_phase_reg)
                    state_next = EXEC;
                else
                    state_next = FINISH;
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs lag the state by one edge: each cycle shows what the current state decided.
    always_comb begin
        logic          route_en, operand_phase;
        logic [SW-1:0] route_dst, route_val;
        for (int i = 0; i < NUM_DEST; i++) sel_next[i] = '0;
        we_next       = '0;
        busy_next     = (state_reg != IDLE);
        done_next     = (state_reg == FINISH);
        error_next    = (state_reg == FINISH) && err_reg;
        route_en      = 1'b0;
        operand_phase = 1'b0;
        route_dst     = dst_reg;
        route_val     = src_reg;
        if (state_reg == ADDR) begin
            route_en  = 1'b1;
            route_dst = DST_ADD;
            route_val = SRC_IMM;
        end else if (state_reg == ROUTE || state_reg == WRITE) begin
            case (op_reg)
                OP_TRANSFER: route_en = 1'b1;
                OP_LOAD_IMM: begin route_en = 1'b1; route_val = SRC_IMM; end
                OP_LOAD_MEM: begin route_en = 1'b1; route_val = SRC_MEM; end
                OP_STORE:    begin route_en = 1'b1; route_dst = DST_MEM; end
                OP_ALU: begin
                    if (result_phase_reg) begin
                        route_en  = 1'b1;
                        route_val = SRC_ALU;
                    end else begin
                        operand_phase = 1'b1;
                    end
                end
                default: route_en = 1'b0;
            endcase
        end
        for (int i = 0; i < NUM_DEST; i++) begin
            if (route_en && route_dst == SW'(i)) begin
                sel_next[i] = route_val;
                we_next[i]  = (state_reg == WRITE) || (state_reg == ADDR && addr_phase_reg);
            end
        end
        if (operand_phase) begin
            sel_next[NUM_DEST-2] = src_reg;
            sel_next[NUM_DEST-1] = SRC_IMM;
            we_next[NUM_DEST-2]  = (state_reg == WRITE);
            we_next[NUM_DEST-1]  = (state_reg == WRITE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            op_reg           <= '0;
            src_reg          <= '0;
            dst_reg          <= '0;
            addr_phase_reg   <= 1'b0;
            result_phase_reg <= 1'b0;
            err_reg          <= 1'b0;
            cnt_reg          <= '0;
            for (int i = 0; i < NUM_DEST; i++) sel_reg[i] <= '0;
            we_reg           <= '0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            error_reg        <= 1'b0;
        end else begin
            state_reg        <= state_next;
            op_reg           <= op_next;
            src_reg          <= src_next;
            dst_reg          <= dst_next;
            addr_phase_reg   <= addr_phase_next;
            result_phase_reg <= result_phase_next;
            err_reg          <= err_next;
            cnt_reg          <= cnt_next;
            for (int i = 0; i < NUM_DEST; i++) sel_reg[i] <= sel_next[i];
            we_reg           <= we_next;
            busy_reg         <= busy_next;
            done_reg         <= done_next;
            error_reg        <= error_next;
        end
    end

    assign pc_selector     = sel_reg[0];
    assign sp_selector     = sel_reg[1];
    assign add_selector    = sel_reg[2];
    assign x_selector      = sel_reg[3];
    assign y_selector      = sel_reg[4];
    assign stat_selector   = sel_reg[5];
    assign mem_selector    = sel_reg[6];
    assign fetch_selector  = sel_reg[7];
    assign decode_selector = sel_reg[8];
    assign alu0_selector   = sel_reg[9];
    assign alu1_selector   = sel_reg[10];
    assign dst_we          = we_reg;
    assign busy            = busy_reg;
    assign done            = done_reg;
    assign error           = error_reg;
endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer: cycle-exact expectations for each op type,
// wait states, timeout, illegal ops, ignored start and mid-op reset.
module tb_bus_sequencer;
    logic        clk = 1'b0;
    logic        reset_n, start, mem_ready, alu_done;
    logic [2:0]  op_type;
    logic [3:0]  src_code, dst_code;
    logic [3:0]  pc_s, sp_s, add_s, x_s, y_s, stat_s, mem_s, fetch_s, dec_s, alu0_s, alu1_s;
    logic [10:0] dst_we;
    logic        busy, done, error;
    logic [43:0] sel_bus;

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    bus_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op_type(op_type),
        .src_code(src_code), .dst_code(dst_code), .mem_ready(mem_ready), .alu_done(alu_done),
        .pc_selector(pc_s), .sp_selector(sp_s), .add_selector(add_s), .x_selector(x_s),
        .y_selector(y_s), .stat_selector(stat_s), .mem_selector(mem_s),
        .fetch_selector(fetch_s), .decode_selector(dec_s), .alu0_selector(alu0_s),
        .alu1_selector(alu1_s), .dst_we(dst_we), .busy(busy), .done(done), .error(error)
    );

    assign sel_bus = {alu1_s, alu0_s, dec_s, fetch_s, mem_s, stat_s, y_s, x_s, add_s, sp_s, pc_s};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [43:0] sv(input int idx, input logic [3:0] val);
        logic [43:0] v;
        v = '0;
        v[idx*4 +: 4] = val;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] src, input logic [3:0] dst);
        start = 1'b1; op_type = op; src_code = src; dst_code = dst;
        tick();
        start = 1'b0;
    endtask

    task automatic expect_error_op(input string tag, input logic [2:0] op,
                                   input logic [3:0] src, input logic [3:0] dst);
        issue(op, src, dst);
        tick();
        check_eq({tag, "_done"}, done, 1);
        check_eq({tag, "_error"}, error, 1);
        check_eq({tag, "_we"}, dst_we, 0);
        tick();
        check_eq({tag, "_after"}, {busy, done}, 0);
    endtask

    initial begin
        int bad;
        reset_n = 1'b0; start = 1'b0; op_type = '0; src_code = '0; dst_code = '0;
        mem_ready = 1'b0; alu_done = 1'b0;
        #12;
        check_eq("rst_sel", sel_bus, 0);
        check_eq("rst_flags", {dst_we, busy, done, error}, 0);
        @(negedge clk) reset_n = 1'b1;
        tick();

        // TRANSFER x -> y
        issue(3'd1, 4'd4, 4'd4);
        tick(); check_eq("xfer_route_sel", sel_bus, sv(4, 4)); check_eq("xfer_route_we", dst_we, 0);
        check_eq("xfer_busy", busy, 1);
        tick(); check_eq("xfer_write_sel", sel_bus, sv(4, 4)); check_eq("xfer_write_we", dst_we, 11'h010);
        check_eq("xfer_done_early", done, 0);
        tick(); check_eq("xfer_done", {done, error}, 2'b10); check_eq("xfer_fin_sel", sel_bus, 0);
        check_eq("xfer_fin_we", dst_we, 0);
        tick(); check_eq("xfer_idle", {busy, done}, 0);

        // LOAD_IMM into pc
        issue(3'd2, 4'd0, 4'd0);
        tick(); check_eq("ldi_sel", sel_bus, sv(0, 8));
        tick(); check_eq("ldi_we", dst_we, 11'h001);
        tick(); check_eq("ldi_done", {done, error}, 2'b10);

        // LOAD_MEM into x, mem_ready low for three wait cycles
        issue(3'd3, 4'd0, 4'd3);
        tick(); check_eq("ldm_addr1", {sel_bus, dst_we}, {sv(2, 8), 11'h000});
        tick(); check_eq("ldm_addr2", {sel_bus, dst_we}, {sv(2, 8), 11'h004});
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 2) mem_ready = 1'b1;
            if (dst_we != 0 || sel_bus != 0 || done || !busy) bad++;
        end
        check_eq("ldm_wait_quiet", bad, 0);
        mem_ready = 1'b0;
        tick(); check_eq("ldm_route", {sel_bus, dst_we}, {sv(3, 7), 11'h000});
        tick(); check_eq("ldm_write", {sel_bus, dst_we}, {sv(3, 7), 11'h008});
        tick(); check_eq("ldm_done", {done, error}, 2'b10);
        tick(); check_eq("ldm_single_done", done, 0);

        // STORE from y, memory never ready: 15 wait cycles then error
        issue(3'd4, 4'd5, 4'd0);
        tick(); tick(); tick();
        check_eq("st_route", {sel_bus, dst_we}, {sv(6, 5), 11'h000});
        tick(); check_eq("st_write", {sel_bus, dst_we}, {sv(6, 5), 11'h040});
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (dst_we != 0 || done || error) bad++;
        end
        check_eq("st_wait_quiet", bad, 0);
        tick(); check_eq("st_timeout", {done, error, dst_we}, {2'b11, 11'h000});
        tick(); check_eq("st_idle", {busy, done, error}, 0);

        // ALU x op imm -> x, alu_done after one EXEC cycle
        issue(3'd5, 4'd4, 4'd3);
        tick(); check_eq("alu_operands", {sel_bus, dst_we}, {sv(9, 4) | sv(10, 8), 11'h000});
        tick(); check_eq("alu_opwrite", {sel_bus, dst_we}, {sv(9, 4) | sv(10, 8), 11'h600});
        tick(); alu_done = 1'b1;
        check_eq("alu_exec", {sel_bus, dst_we}, {44'h0, 11'h000});
        tick(); alu_done = 1'b0;
        tick(); check_eq("alu_result", {sel_bus, dst_we}, {sv(3, 11), 11'h000});
        tick(); check_eq("alu_reswrite", {sel_bus, dst_we}, {sv(3, 11), 11'h008});
        tick(); check_eq("alu_done", {done, error}, 2'b10);

        // Illegal requests
        expect_error_op("ill_op7", 3'd7, 4'd1, 4'd0);
        expect_error_op("ill_dst12", 3'd1, 4'd1, 4'd12);
        expect_error_op("ill_self", 3'd1, 4'd4, 4'd3);

        // start held while busy must not queue a second op
        issue(3'd1, 4'd1, 4'd2);
        start = 1'b1; op_type = 3'd0;
        tick(); check_eq("ign_sel", sel_bus, sv(2, 1));
        tick(); check_eq("ign_we", dst_we, 11'h004);
        tick(); start = 1'b0;
        check_eq("ign_done", {done, error}, 2'b10);
        tick(); check_eq("ign_no_extra1", {busy, done}, 0);
        tick(); check_eq("ign_no_extra2", done, 0);

        // Reset during MEMWAIT
        issue(3'd3, 4'd0, 4'd3);
        tick(); tick(); tick(); tick();
        check_eq("rmid_busy_pre", busy, 1);
        reset_n = 1'b0;
        #1;
        check_eq("rmid_outputs", {sel_bus, dst_we, busy, done, error}, 0);
        @(negedge clk) reset_n = 1'b1;
        mem_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (busy || done || dst_we != 0) bad++;
        end
        check_eq("rmid_quiet", bad, 0);
        mem_ready = 1'b0;

        // NOP after reset completes one cycle after start
        issue(3'd0, 4'd0, 4'd0);
        tick(); check_eq("nop_done", {done, error}, 2'b10);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
